// File: rtl/display_seq_pkg.sv
// ============================================================================
// Module   : display_seq_pkg
// Brief    : Shared types and helpers for the display sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package display_seq_pkg;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_e;

  // Width of the speed level register; a single level still needs one bit.
  function automatic int speed_w(input int num_speeds);
    return (num_speeds > 2) ? $clog2(num_speeds) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/display_sequencer_btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Brief    : Two-flop synchroniser and stability counter for one active-low
//            button; emits a one-cycle press pulse on an accepted 1->0 change.
// Revision : 1.0
// ============================================================================
`default_nettype none

module btn_debounce
  import display_seq_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only advances while the synchronised pin disagrees with level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync2_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
    press_d = level_q & ~level_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

`default_nettype wire

// File: rtl/display_sequencer.sv
// ============================================================================
// Module   : display_sequencer
// Brief    : Steps a pattern ROM address at a button-selected rate and drives
//            the fetched word onto the LEDs. DISPLAY_SEQ_DIR_EN adds reverse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module display_sequencer
  import display_seq_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int ADDR_MAX   = 2**ADDR_W - 1,
  parameter int NUM_SPEEDS = 4,
  parameter int BASE_DIV   = 50_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             btn_p,
  input  logic                             btn_spdup,
  input  logic                             btn_spddn,
  input  logic                             btn_dir,
  input  logic [DATA_W-1:0]                mem_data,
  output logic [ADDR_W-1:0]                addr,
  output logic [DATA_W-1:0]                led_data,
  output logic                             paused,
  output logic [speed_w(NUM_SPEEDS)-1:0]   speed_lvl
);

  localparam int SPD_W = speed_w(NUM_SPEEDS);
  localparam int DIV_W = (BASE_DIV > 2) ? $clog2(BASE_DIV) : 1;
  localparam logic [DIV_W:0]    BASE_V    = (DIV_W+1)'(BASE_DIV);
  localparam logic [SPD_W-1:0]  LVL_TOP   = SPD_W'(NUM_SPEEDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ADDR_MAX);

  logic p_press, up_press, dn_press;
  logic lvl_unused_p, lvl_unused_up, lvl_unused_dn;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_p (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_p),     .level(lvl_unused_p),  .press(p_press));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_spdup), .level(lvl_unused_up), .press(up_press));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_spddn), .level(lvl_unused_dn), .press(dn_press));

  dir_e dir_d;

`ifdef DISPLAY_SEQ_DIR_EN
  logic lvl_unused_dir, dir_press;
  dir_e dir_q;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_dir), .level(lvl_unused_dir), .press(dir_press));

  // A tick in the same cycle as the press already follows the new direction.
  always_comb begin
    dir_d = dir_q;
    if (dir_press) dir_d = (dir_q == DIR_FWD) ? DIR_REV : DIR_FWD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_q <= DIR_FWD;
    else        dir_q <= dir_d;
  end
`else
  logic btn_dir_unused;
  assign btn_dir_unused = btn_dir;
  assign dir_d          = DIR_FWD;
`endif

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] led_data_q;
  logic              paused_q, paused_d;
  logic [SPD_W-1:0]  speed_lvl_q, speed_lvl_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W:0]    period_m1;
  logic              tick;

  always_comb begin
    paused_d    = paused_q ^ p_press;
    speed_lvl_d = speed_lvl_q;
    if (up_press && !dn_press && speed_lvl_q != LVL_TOP)
      speed_lvl_d = speed_lvl_q + 1'b1;
    else if (dn_press && !up_press && speed_lvl_q != '0)
      speed_lvl_d = speed_lvl_q - 1'b1;

    period_m1 = (BASE_V >> speed_lvl_q) - 1'b1;
    // A pause press landing on the terminal count swallows that step.
    tick = !paused_q && !p_press && ({1'b0, div_q} == period_m1);

    div_d = div_q + 1'b1;
    if (paused_q || p_press || up_press || dn_press || tick) div_d = '0;

    addr_d = addr_q;
    if (tick) begin
      if (dir_d == DIR_REV) addr_d = (addr_q == '0)        ? ADDR_LAST : addr_q - 1'b1;
      else                  addr_d = (addr_q == ADDR_LAST) ? '0        : addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      led_data_q  <= '0;
      paused_q    <= 1'b0;
      speed_lvl_q <= '0;
      div_q       <= '0;
    end else begin
      addr_q      <= addr_d;
      led_data_q  <= mem_data;
      paused_q    <= paused_d;
      speed_lvl_q <= speed_lvl_d;
      div_q       <= div_d;
    end
  end

  assign addr      = addr_q;
  assign led_data  = led_data_q;
  assign paused    = paused_q;
  assign speed_lvl = speed_lvl_q;

endmodule

`default_nettype wire

// File: tb/tb_display_sequencer.sv
// ============================================================================
// Module   : tb_display_sequencer
// Brief    : Self-checking bench for display_sequencer with a random ROM and
//            randomised button timing; honours DISPLAY_SEQ_DIR_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_display_sequencer;

  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 8;
  localparam int ADDR_MAX   = 9;
  localparam int NUM_SPEEDS = 4;
  localparam int BASE_DIV   = 16;
  localparam int DEB_CYCLES = 4;
  localparam int SETTLE     = DEB_CYCLES + 4;
  localparam int STEP_BOUND = 2 * BASE_DIV + 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              btn_p = 1'b1, btn_spdup = 1'b1, btn_spddn = 1'b1, btn_dir = 1'b1;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] led_data;
  logic              paused;
  logic [1:0]        speed_lvl;

  logic [DATA_W-1:0] rom [16];
  int cyc = 0;
  int checks = 0, errors = 0;
  int since_rst = 0;
  int hold_p = 0, hold_up = 0, hold_dn = 0, hold_dir = 0;
  int lat = DEB_CYCLES + 3;
  int exp_lvl = 0;
  bit exp_paused = 1'b0;
  bit exp_rev = 1'b0;
  int h1 = 0, h2 = 0;

  display_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_MAX(ADDR_MAX),
    .NUM_SPEEDS(NUM_SPEEDS), .BASE_DIV(BASE_DIV), .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_p(btn_p), .btn_spdup(btn_spdup),
    .btn_spddn(btn_spddn), .btn_dir(btn_dir), .mem_data(mem_data),
    .addr(addr), .led_data(led_data), .paused(paused), .speed_lvl(speed_lvl)
  );

  always #5 clk = ~clk;

  // Synchronous pattern ROM: data valid one cycle after the address.
  always @(posedge clk) begin
    mem_data <= rom[addr];
    cyc      <= cyc + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // LED output must show the ROM word for the address from two cycles ago.
  always @(negedge clk) begin
    if (!rst_n) since_rst = 0;
    else        since_rst++;
    if (since_rst >= 3) check("led_follow", led_data, rom[h2]);
    h2 = h1;
    h1 = addr;
  end

  function automatic int nxt(input int a);
    if (exp_rev) return (a == 0) ? ADDR_MAX : a - 1;
    return (a == ADDR_MAX) ? 0 : a + 1;
  endfunction

  task automatic step();
    @(negedge clk);
    if (hold_p   > 0) begin hold_p--;   if (hold_p   == 0) btn_p     = 1'b1; end
    if (hold_up  > 0) begin hold_up--;  if (hold_up  == 0) btn_spdup = 1'b1; end
    if (hold_dn  > 0) begin hold_dn--;  if (hold_dn  == 0) btn_spddn = 1'b1; end
    if (hold_dir > 0) begin hold_dir--; if (hold_dir == 0) btn_dir   = 1'b1; end
  endtask

  // which: 0 pause, 1 up, 2 down, 3 up+down together, 4 direction
  task automatic push(input int which, input int n);
    case (which)
      0: begin btn_p = 1'b0; hold_p = n; end
      1: begin btn_spdup = 1'b0; hold_up = n; end
      2: begin btn_spddn = 1'b0; hold_dn = n; end
      3: begin btn_spdup = 1'b0; hold_up = n; btn_spddn = 1'b0; hold_dn = n; end
      default: begin btn_dir = 1'b0; hold_dir = n; end
    endcase
  endtask

  task automatic wait_change(output int waited);
    int a;
    a = addr;
    waited = 0;
    while (addr == a && waited < STEP_BOUND) begin step(); waited++; end
  endtask

  task automatic expect_steps(input int n, input string tag);
    int prev, last, w;
    last = -1;
    for (int i = 0; i < n; i++) begin
      prev = addr;
      wait_change(w);
      check({tag, "_val"}, addr, nxt(prev));
      if (addr == prev) return;
      if (last >= 0) check({tag, "_period"}, cyc - last, BASE_DIV >> exp_lvl);
      last = cyc;
    end
  endtask

  // Press a button, predict the flags from the spec rules, and time the next step.
  task automatic press_timed(input int which, input string tag);
    int f, w, a;
    push(which, DEB_CYCLES + 2 + $urandom_range(0, 4));
    f = cyc;
    case (which)
      0: exp_paused = !exp_paused;
      1: exp_lvl = (exp_lvl < NUM_SPEEDS - 1) ? exp_lvl + 1 : exp_lvl;
      2: exp_lvl = (exp_lvl > 0) ? exp_lvl - 1 : 0;
`ifdef DISPLAY_SEQ_DIR_EN
      4: exp_rev = !exp_rev;
`endif
      default: ;
    endcase
    while (cyc < f + lat) step();
    check({tag, "_lvl"}, speed_lvl, exp_lvl);
    check({tag, "_paused"}, paused, exp_paused);
    if (!exp_paused) begin
      a = addr;
      wait_change(w);
      if (which != 4) check({tag, "_first_step"}, cyc - (f + lat), BASE_DIV >> exp_lvl);
      check({tag, "_next_addr"}, addr, nxt(a));
    end
    while (hold_p > 0 || hold_up > 0 || hold_dn > 0 || hold_dir > 0) step();
    repeat (SETTLE) step();
  endtask

  task automatic release_and_check(input string tag);
    int rel, w;
    @(negedge clk);
    #2 rst_n = 1'b1;
    rel = cyc;
    wait_change(w);
    check({tag, "_first_lat"}, cyc - rel, BASE_DIV);
    check({tag, "_first_val"}, addr, 1);
  endtask

  initial begin
    int f, t, a;
    for (int i = 0; i < 16; i++) rom[i] = DATA_W'($urandom);

    repeat (3) step();
    check("rst_addr", addr, 0);
    check("rst_led", led_data, 0);
    check("rst_paused", paused, 0);
    check("rst_lvl", speed_lvl, 0);
    release_and_check("boot");
    expect_steps(10, "walk");

    // Short bounce must not register.
    push(0, $urandom_range(1, 3));
    repeat (12) step();
    check("bounce_paused", paused, 0);

    push(0, DEB_CYCLES + 3);
    f = cyc;
    t = 0;
    while (paused !== 1'b1 && t < 4 * DEB_CYCLES + 10) begin step(); t++; end
    lat = cyc - f;
    check("pause_lat_window", int'(lat >= DEB_CYCLES + 3 && lat <= DEB_CYCLES + 5), 1);
    check("pause_on", paused, 1);
    exp_paused = 1'b1;
    if (lat < DEB_CYCLES + 3 || lat > DEB_CYCLES + 5) lat = DEB_CYCLES + 3;
    repeat (SETTLE + 2) step();
    a = addr;
    repeat (2 * BASE_DIV) step();
    check("pause_frozen", addr, a);
    press_timed(0, "resume");

    for (int i = 0; i < 4; i++) press_timed(1, "spdup");
    expect_steps(3, "top_speed");
    for (int i = 0; i < 4; i++) press_timed(2, "spddn");
    press_timed(1, "pre_both");
    press_timed(3, "both");
    press_timed(2, "post_both");

    t = 0;
    while (addr != 1 && t < 12 * BASE_DIV) begin step(); t++; end
    check("reach1", addr, 1);
    press_timed(4, "dir1");
    expect_steps(2, "dir1");
    press_timed(4, "dir2");
    expect_steps(2, "dir2");

    for (int i = 0; i < 6; i++) press_timed($urandom_range(1, 3), "rnd");
    repeat (3) press_timed(2, "home");

    t = 0;
    while (addr != 5 && t < 12 * BASE_DIV) begin step(); t++; end
    check("reach5", addr, 5);
    press_timed(0, "pre_rst_pause");
    press_timed(1, "pre_rst_up");
    press_timed(1, "pre_rst_up");
    check("pre_rst_addr", addr, 5);

    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_addr", addr, 0);
    check("async_rst_led", led_data, 0);
    check("async_rst_paused", paused, 0);
    check("async_rst_lvl", speed_lvl, 0);
    exp_lvl = 0;
    exp_paused = 1'b0;
    exp_rev = 1'b0;
    repeat (2) step();
    release_and_check("post_rst");
    expect_steps(3, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/display_sequencer.md
# display_sequencer

Parametrised LED playback controller: steps an address through a synchronous pattern ROM at a button-selectable rate and drives the fetched word onto the board LEDs. Three active-low push buttons are debounced on-chip: pause/resume, speed up, speed down. A fourth button reverses playback direction. Sits between the board buttons, the pattern ROM and the LED pins; generalises the fixed 8-bit controller to arbitrary address/data widths, speed levels and wrap point.

## Interface
- ADDR_W, 8, ROM address width
- DATA_W, 8, ROM/LED data width
- ADDR_MAX, 2**ADDR_W-1, last played address; wrap point
- NUM_SPEEDS, 4, number of speed levels (≥2)
- BASE_DIV, 50_000_000, clock cycles per step at level 0; BASE_DIV>>(NUM_SPEEDS-1) ≥ 2
- DEB_CYCLES, 1_000_000, cycles a synchronised button level must be stable before acceptance
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_p  in  1  pause/resume toggle, active-low, asynchronous
- btn_spdup  in  1  speed up, active-low, asynchronous
- btn_spddn  in  1  speed down, active-low, asynchronous
- btn_dir  in  1  direction toggle, active-low, asynchronous
- mem_data  in  DATA_W  ROM read data, valid one cycle after addr
- addr  out  ADDR_W  ROM address
- led_data  out  DATA_W  registered LED drive
- paused  out  1  1 = playback halted
- speed_lvl  out  $clog2(NUM_SPEEDS)  current level, 0 = slowest

## Operation
- Reset values: addr=0, led_data=0, paused=0, speed_lvl=0, direction=forward, divider=0, debouncers released (1).
- Each button: 2-FF synchroniser, then stability counter; debounced level updates only after DEB_CYCLES consecutive identical samples. A 1->0 transition of the debounced level yields a one-cycle press pulse; release produces nothing.
- Pause press toggles paused. Spdup press: speed_lvl+1, saturate at NUM_SPEEDS-1. Spddn press: speed_lvl-1, saturate at 0. Both in the same cycle: no change. Dir press toggles direction.
- Step period P = BASE_DIV >> speed_lvl. Divider counts 0..P-1 while running; at P-1 it issues a tick and returns to 0.
- Tick: forward addr = (addr==ADDR_MAX) ? 0 : addr+1; reverse addr = (addr==0) ? ADDR_MAX : addr-1.
- led_data <= mem_data every cycle, including while paused.

## Timing
- Press pulse: DEB_CYCLES+3 cycles after pin falls (2 sync + DEB_CYCLES stable + edge register), ±1.
- Flags update on the clock edge after the press pulse.
- Speed change (including a saturated no-op press): divider cleared to 0; next tick P_new cycles later.
- Paused: divider held at 0; resume: first tick exactly P cycles after paused falls.
- Pause press in the same cycle as a tick: tick suppressed. Dir press in the same cycle as a tick: tick uses the new direction.
- led_data reflects addr two cycles later (ROM register + output register).
- rst_n asserted mid-step: all state returns to reset values immediately; divider progress is lost.

## Configuration
- DISPLAY_SEQ_DIR_EN defined: btn_dir debouncer and reverse stepping are compiled in.
- Undefined: btn_dir port remains but is ignored; no debouncer is instantiated; direction is permanently forward.

## Structure
- Package display_seq_pkg: dir_e enum (DIR_FWD, DIR_REV) and a function computing speed_lvl width from NUM_SPEEDS.
- Sub-module btn_debounce (parameter DEB_CYCLES; ports clk, rst_n, btn_n, level, press). Instantiated three times, or four with DISPLAY_SEQ_DIR_EN.

## Test plan
Bench parameters: ADDR_W=4, ADDR_MAX=9, NUM_SPEEDS=4, BASE_DIV=16, DEB_CYCLES=4.
- Reset, no buttons -> addr steps 0,1,…,9,0 every 16 cycles; led_data follows the ROM 2 cycles behind each addr change.
- btn_p low 2 cycles then high (bounce) -> no press; btn_p held low 10 cycles -> paused=1, addr frozen. Second press -> paused=0; next step 16 cycles after paused falls.
- Spdup pressed 4 times -> speed_lvl 1,2,3,3; step period 8,4,2,2. Spddn pressed 4 times -> back down to 0, saturating there.
- Spdup and spddn pulses in the same cycle -> speed_lvl unchanged, divider cleared.
- DISPLAY_SEQ_DIR_EN, addr=1, dir press -> addr steps 0,9,8; press again -> steps forward. Without the macro, the same stimulus leaves addr moving forward.
- rst_n pulsed low with addr=5, paused=1, speed_lvl=2 -> all outputs return to reset values asynchronously; playback resumes from 0 at 16-cycle steps.
